cnt_ctrl: RTL and testbench
===========================

CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 100000, consecutive stable cycles required before a debounced button changes state (minimum 2).
REQ-002 Parameter: HOLD_CYCLES, default 50000000, hold time before auto-repeat starts (used only with the macro in REQ-024).
REQ-003 Parameter: REPEAT_CYCLES, default 10000000, auto-repeat pulse period (used only with the macro in REQ-024).
REQ-004 Port: clk  input  1  single system clock; all logic on the rising edge.
REQ-005 Port: rst  input  1  one clock, reset synchronous and active-low.
REQ-006 Port: btn_up  input  1  raw asynchronous count-up button, bouncy.
REQ-007 Port: btn_dn  input  1  raw asynchronous count-down button, bouncy.
REQ-008 Port: btn_ld  input  1  raw asynchronous load button, bouncy.
REQ-009 Port: sw  input  4  raw asynchronous load-value switches.
REQ-010 Port: en  output  1  counter enable pulse to downstream cnt.
REQ-011 Port: up  output  1  direction to cnt; 1 = up, 0 = down.
REQ-012 Port: load  output  1  load pulse to cnt.
REQ-013 Port: count_in  output  4  synchronized load value to cnt.

Function
REQ-014 Each button and each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each button SHALL have one debouncer FSM with states IDLE, WAIT_HI, HIGH, WAIT_LO and a counter of width $clog2(DEBOUNCE_CYCLES)+1.
- IDLE -> WAIT_HI when sync=1.
- WAIT_HI -> HIGH after DEBOUNCE_CYCLES consecutive cycles of sync=1.
- WAIT_HI -> IDLE on any sync=0, with counter cleared.
- HIGH and WAIT_LO SHALL mirror IDLE and WAIT_HI with the polarity inverted.
REQ-016 Each debouncer SHALL produce a 1-cycle press strobe on the IDLE/WAIT_HI -> HIGH transition only; release SHALL produce no strobe.
REQ-017 Latency: a raw button held steady high SHALL cause its output pulse exactly DEBOUNCE_CYCLES+3 rising edges after the first edge at which raw=1 is sampled.
REQ-018 The up strobe SHALL drive en=1 and up=1 for exactly one cycle.
REQ-019 The down strobe SHALL drive en=1 and up=0 for exactly one cycle.
REQ-020 The load strobe SHALL drive load=1 and en=0 for exactly one cycle.
REQ-021 Simultaneous strobes:
- load with any other strobe: load SHALL win and the others are discarded.
- up and down together without load: both SHALL be discarded and all outputs stay 0.
REQ-022 When no strobe is present, en, load and up SHALL be 0.
REQ-023 count_in SHALL equal the 2-flop-synchronized sw, updated every cycle, independent of buttons.

Configuration
REQ-024 With CNT_CTRL_AUTOREPEAT_EN defined:
- btn_up or btn_dn held in HIGH for HOLD_CYCLES SHALL emit an additional en pulse (same up value) every REPEAT_CYCLES until the button leaves HIGH.
- Load SHALL never repeat.
REQ-025 Without CNT_CTRL_AUTOREPEAT_EN, exactly one pulse per press SHALL be emitted; HOLD_CYCLES and REPEAT_CYCLES are unused and SHALL produce no hold or repeat counter logic.

Reset
REQ-026 While rst=0 at a rising edge:
- all FSMs SHALL go to IDLE.
- all counters and synchronizer flops SHALL clear to 0.
- en, up and load SHALL be 0, and count_in SHALL be 4'h0 on the next cycle.
REQ-027 Reset mid-debounce or mid-hold SHALL discard the partial count; after release, a still-pressed button SHALL restart a full debounce and emit one pulse.

Structure
REQ-028 Package cnt_ctrl_pkg SHALL hold:
- the debouncer state enum.
- the DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES default constants.
REQ-029 The synchronizer, FSM and strobe logic SHALL live in sub-module debounce, instantiated three times; arbitration and auto-repeat stay in cnt_ctrl.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8 for sim)
REQ-030 The bench SHALL drive rst=0 for 4 cycles, then rst=1 with all inputs 0 -> en=load=up=0 and count_in=0 throughout.
REQ-031 The bench SHALL hold btn_up=1 clean for 30 cycles -> exactly one en=1,up=1 pulse, 7 edges after the first sampled high; none on release.
REQ-032 The bench SHALL bounce btn_dn 1,0,1,0 at 1-cycle intervals, then hold it high -> a single en=1,up=0 pulse, 7 edges after the final rise.
REQ-033 The bench SHALL set sw=4'hA and press btn_ld and btn_up on the same edge -> count_in=4'hA and a single load=1 pulse with en=0, with no en pulse.
REQ-034 The bench SHALL assert rst=0 for 1 cycle, 3 cycles into the btn_up debounce -> no pulse at the original time, and a pulse 7 edges after rst returns to 1.
REQ-035 With CNT_CTRL_AUTOREPEAT_EN, the bench SHALL hold btn_up for 60 cycles -> the first pulse, then a pulse 20 cycles later, then every 8 cycles until release.

Source files
------------

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and default timing constants for the counter control front end.
// The debouncer state enum lives here so the top and the debouncer agree on it.
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } db_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;
    localparam int DEFAULT_HOLD_CYCLES     = 50000000;
    localparam int DEFAULT_REPEAT_CYCLES   = 10000000;

endpackage

// File: rtl/cnt_ctrl_debounce.sv
// Single-button front end: 2-flop synchronizer, debounce FSM and a registered
// one-cycle press strobe. The 'high' level tells the top when the button is held.
module debounce
    import cnt_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press,
    output logic high
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    db_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            press_q, press_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // The counter only survives while a WAIT state keeps seeing the new level;
    // any glitch back to the old level drops it to zero.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = HIGH;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!sync2_q) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign press = press_q;
    assign high  = (state_q == HIGH);

endmodule

// File: rtl/cnt_ctrl.sv
// Button/switch front end for the counter: debounces up/down/load and arbitrates
// them into en/up/load pulses. Define CNT_CTRL_AUTOREPEAT_EN for held-button auto-repeat.
module cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_ld,
    input  logic [3:0] sw,
    output logic       en,
    output logic       up,
    output logic       load,
    output logic [3:0] count_in
);

    logic [3:0] sw_sync1_q, sw_sync1_d;
    logic [3:0] sw_sync2_q, sw_sync2_d;
    logic       en_q, en_d;
    logic       up_q, up_d;
    logic       load_q, load_d;

    logic       up_press, dn_press, ld_press;
    logic       up_high, dn_high, ld_high_unused;
    logic       up_evt, dn_evt;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_up),
        .press (up_press),
        .high  (up_high)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_dn),
        .press (dn_press),
        .high  (dn_high)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ld (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_ld),
        .press (ld_press),
        .high  (ld_high_unused)
    );

`ifdef CNT_CTRL_AUTOREPEAT_EN
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    // Index 0 tracks the up button, index 1 the down button.
    logic [1:0][HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]         rpt_q, rpt_d;
    logic [1:0]         rep_fire;
    logic [1:0]         high_vec;

    assign high_vec = {dn_high, up_high};

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt_q <= '0;
            rpt_q      <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            rpt_q      <= rpt_d;
        end
    end

    // First target is the hold time measured from entry into HIGH; after the
    // first repeat the same counter restarts at 1 and targets the repeat period.
    always_comb begin
        hold_cnt_d = '0;
        rpt_d      = '0;
        rep_fire   = '0;
        for (int i = 0; i < 2; i++) begin
            if (high_vec[i]) begin
                if (hold_cnt_q[i] == (rpt_q[i] ? HW'(REPEAT_CYCLES) : HW'(HOLD_CYCLES))) begin
                    rep_fire[i]   = 1'b1;
                    hold_cnt_d[i] = HW'(1);
                    rpt_d[i]      = 1'b1;
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    rpt_d[i]      = rpt_q[i];
                end
            end
        end
    end

    assign up_evt = up_press | rep_fire[0];
    assign dn_evt = dn_press | rep_fire[1];
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{up_high, dn_high, HOLD_CYCLES[0], REPEAT_CYCLES[0]};

    assign up_evt = up_press;
    assign dn_evt = dn_press;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            en_q       <= 1'b0;
            up_q       <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            sw_sync1_q <= sw_sync1_d;
            sw_sync2_q <= sw_sync2_d;
            en_q       <= en_d;
            up_q       <= up_d;
            load_q     <= load_d;
        end
    end

    // Load beats everything; conflicting up and down cancel each other out.
    always_comb begin
        sw_sync1_d = sw;
        sw_sync2_d = sw_sync1_q;
        en_d       = 1'b0;
        up_d       = 1'b0;
        load_d     = 1'b0;
        if (ld_press) begin
            load_d = 1'b1;
        end else if (up_evt && !dn_evt) begin
            en_d = 1'b1;
            up_d = 1'b1;
        end else if (dn_evt && !up_evt) begin
            en_d = 1'b1;
        end
    end

    assign en       = en_q;
    assign up       = up_q;
    assign load     = load_q;
    assign count_in = sw_sync2_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: scenario tasks compared step by step against
// a run-length debounce model; honours CNT_CTRL_AUTOREPEAT_EN when defined.
module tb_cnt_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int NMAX = 256;
`ifdef CNT_CTRL_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0, btn_dn = 1'b0, btn_ld = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       en, up, load;
    logic [3:0] count_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-step stimulus and expected outputs; step k is applied before edge k.
    bit       raw_up [NMAX];
    bit       raw_dn [NMAX];
    bit       raw_ld [NMAX];
    bit       rst_v  [NMAX];
    bit [3:0] sw_v   [NMAX];
    bit       e_en   [NMAX];
    bit       e_up   [NMAX];
    bit       e_ld   [NMAX];
    bit [3:0] e_cin  [NMAX];
    bit       ev_tbl [3][NMAX];
    int       n_steps;

    cnt_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .btn_ld   (btn_ld),
        .sw       (sw),
        .en       (en),
        .up       (up),
        .load     (load),
        .count_in (count_in)
    );

    always #5 clk = ~clk;

    task automatic clear_stim(input int n);
        n_steps = n;
        for (int k = 0; k < NMAX; k++) begin
            raw_up[k] = 1'b0;
            raw_dn[k] = 1'b0;
            raw_ld[k] = 1'b0;
            sw_v[k]   = 4'h0;
            rst_v[k]  = (k >= 2);
        end
    endtask

    function automatic bit raw_of(input int b, input int k);
        case (b)
            0:       return raw_up[k];
            1:       return raw_dn[k];
            default: return raw_ld[k];
        endcase
    endfunction

    // Repeat pulses for a stretch of HIGH that began at edge h, cut off at qmax.
    task automatic emit_repeats(input int b, input int h, input int qmax);
        if (AUTOREPEAT && b != 2)
            for (int q = h + 1 + HOLD; q <= qmax && q < n_steps; q += REP)
                ev_tbl[b][q] = 1'b1;
    endtask

    // A button's debounced level flips once the raw input has shown the new
    // level for DEB+1 consecutive samples; the press pulse appears 3 steps later.
    task automatic build_model();
        for (int b = 0; b < 3; b++) begin
            bit deb = 1'b0, run_val = 1'b0, in_high = 1'b0, v;
            int run_len = 0, h = 0;
            for (int k = 0; k < NMAX; k++) ev_tbl[b][k] = 1'b0;
            for (int k = 0; k < n_steps; k++) begin
                v = raw_of(b, k);
                if (!rst_v[k]) begin
                    if (in_high) emit_repeats(b, h, k - 1);
                    for (int j = k; j < NMAX; j++) ev_tbl[b][j] = 1'b0;
                    deb = 1'b0; run_val = 1'b0; run_len = 0; in_high = 1'b0;
                end else begin
                    if (v == run_val) run_len++;
                    else begin run_val = v; run_len = 1; end
                    if (v != deb && run_len == DEB + 1) begin
                        deb = v;
                        if (v) begin
                            if (k + 3 < n_steps) ev_tbl[b][k + 3] = 1'b1;
                            h = k + 2;
                            in_high = 1'b1;
                        end
                    end else if (deb) begin
                        if (in_high && !v) begin
                            emit_repeats(b, h, k + 2);
                            in_high = 1'b0;
                        end else if (!in_high && v) begin
                            h = k + 2;
                            in_high = 1'b1;
                        end
                    end
                end
            end
            if (in_high) emit_repeats(b, h, n_steps - 1);
        end
        for (int k = 0; k < n_steps; k++) begin
            e_ld[k]  = ev_tbl[2][k];
            e_en[k]  = !ev_tbl[2][k] && (ev_tbl[0][k] ^ ev_tbl[1][k]);
            e_up[k]  = !ev_tbl[2][k] && ev_tbl[0][k] && !ev_tbl[1][k];
            e_cin[k] = (k == 0 || !rst_v[k] || !rst_v[k - 1]) ? 4'h0 : sw_v[k - 1];
        end
    endtask

    task automatic apply_stimulus(input int k, output logic o_en, output logic o_up,
                                  output logic o_ld, output logic [3:0] o_cin);
        rst    = rst_v[k];
        btn_up = raw_up[k];
        btn_dn = raw_dn[k];
        btn_ld = raw_ld[k];
        sw     = sw_v[k];
        @(posedge clk);
        #1;
        o_en  = en;
        o_up  = up;
        o_ld  = load;
        o_cin = count_in;
    endtask

    task automatic test_reset();
        logic o_en, o_up, o_ld;
        logic [3:0] o_cin;
        clear_stim(12);
        for (int k = 0; k < 4; k++) rst_v[k] = 1'b0;
        build_model();
        for (int k = 0; k < n_steps; k++) begin
            apply_stimulus(k, o_en, o_up, o_ld, o_cin);
            n_checks++;
            if ({o_en, o_up, o_ld, o_cin} !== 7'b0) begin
                n_fail++;
                $display("[TB] FAIL reset step %0d: en,up,load,count_in=%b%b%b %h expected 000 0", k, o_en, o_up, o_ld, o_cin);
            end
        end
    endtask

    task automatic test_clean_press();
        logic o_en, o_up, o_ld;
        logic [3:0] o_cin;
        int n_en = 0, first_en = -1;
        clear_stim(50);
        for (int k = 2; k < 32; k++) raw_up[k] = 1'b1;
        build_model();
        for (int k = 0; k < n_steps; k++) begin
            apply_stimulus(k, o_en, o_up, o_ld, o_cin);
            n_checks++;
            if ({o_en, o_up, o_ld} !== {e_en[k], e_up[k], e_ld[k]}) begin
                n_fail++;
                $display("[TB] FAIL clean_press step %0d: en,up,load=%b%b%b expected %b%b%b", k, o_en, o_up, o_ld, e_en[k], e_up[k], e_ld[k]);
            end
            n_checks++;
            if (o_cin !== e_cin[k]) begin
                n_fail++;
                $display("[TB] FAIL clean_press_cin step %0d: count_in=%h expected %h", k, o_cin, e_cin[k]);
            end
            if (o_en === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = k;
                n_checks++;
                if (o_up !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL clean_press_dir step %0d: up=%b expected 1", k, o_up);
                end
            end
        end
        n_checks++;
        if (n_en != 1 || first_en != 9) begin
            n_fail++;
            $display("[TB] FAIL clean_press_latency: %0d pulses first at %0d, expected 1 at 9", n_en, first_en);
        end
    endtask

    task automatic test_bounce();
        logic o_en, o_up, o_ld;
        logic [3:0] o_cin;
        int n_en = 0, first_en = -1;
        clear_stim(50);
        raw_dn[2] = 1'b1; raw_dn[3] = 1'b0; raw_dn[4] = 1'b1; raw_dn[5] = 1'b0;
        for (int k = 6; k < 36; k++) raw_dn[k] = 1'b1;
        build_model();
        for (int k = 0; k < n_steps; k++) begin
            apply_stimulus(k, o_en, o_up, o_ld, o_cin);
            n_checks++;
            if ({o_en, o_up, o_ld} !== {e_en[k], e_up[k], e_ld[k]}) begin
                n_fail++;
                $display("[TB] FAIL bounce step %0d: en,up,load=%b%b%b expected %b%b%b", k, o_en, o_up, o_ld, e_en[k], e_up[k], e_ld[k]);
            end
            if (o_en === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = k;
                n_checks++;
                if (o_up !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL bounce_dir step %0d: up=%b expected 0", k, o_up);
                end
            end
        end
        n_checks++;
        if (n_en != 1 || first_en != 13) begin
            n_fail++;
            $display("[TB] FAIL bounce_latency: %0d pulses first at %0d, expected 1 at 13", n_en, first_en);
        end
    endtask

    task automatic test_load_priority();
        logic o_en, o_up, o_ld;
        logic [3:0] o_cin;
        int n_en = 0, n_ld = 0, first_ld = -1;
        clear_stim(30);
        for (int k = 0; k < NMAX; k++) sw_v[k] = 4'hA;
        for (int k = 2; k < 21; k++) begin
            raw_ld[k] = 1'b1;
            raw_up[k] = 1'b1;
        end
        build_model();
        for (int k = 0; k < n_steps; k++) begin
            apply_stimulus(k, o_en, o_up, o_ld, o_cin);
            n_checks++;
            if ({o_en, o_up, o_ld} !== {e_en[k], e_up[k], e_ld[k]}) begin
                n_fail++;
                $display("[TB] FAIL load_priority step %0d: en,up,load=%b%b%b expected %b%b%b", k, o_en, o_up, o_ld, e_en[k], e_up[k], e_ld[k]);
            end
            n_checks++;
            if (o_cin !== e_cin[k]) begin
                n_fail++;
                $display("[TB] FAIL load_cin step %0d: count_in=%h expected %h", k, o_cin, e_cin[k]);
            end
            if (o_en === 1'b1) n_en++;
            if (o_ld === 1'b1) begin
                n_ld++;
                if (first_ld < 0) first_ld = k;
            end
        end
        n_checks++;
        if (n_en != 0 || n_ld != 1 || first_ld != 9 || o_cin !== 4'hA) begin
            n_fail++;
            $display("[TB] FAIL load_summary: en pulses %0d, load pulses %0d at %0d, count_in %h; expected 0, 1 at 9, A", n_en, n_ld, first_ld, o_cin);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic o_en, o_up, o_ld;
        logic [3:0] o_cin;
        int n_en = 0, first_en = -1;
        clear_stim(40);
        for (int k = 2; k < 41; k++) raw_up[k] = 1'b1;
        rst_v[5] = 1'b0;
        build_model();
        for (int k = 0; k < n_steps; k++) begin
            apply_stimulus(k, o_en, o_up, o_ld, o_cin);
            n_checks++;
            if ({o_en, o_up, o_ld} !== {e_en[k], e_up[k], e_ld[k]}) begin
                n_fail++;
                $display("[TB] FAIL reset_mid step %0d: en,up,load=%b%b%b expected %b%b%b", k, o_en, o_up, o_ld, e_en[k], e_up[k], e_ld[k]);
            end
            if (o_en === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = k;
            end
        end
        n_checks++;
        if (n_en != 1 || first_en != 13) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_latency: %0d pulses first at %0d, expected 1 at 13", n_en, first_en);
        end
    endtask

    task automatic test_hold();
        logic o_en, o_up, o_ld;
        logic [3:0] o_cin;
        int n_en = 0, first_en = -1, last_en = -1;
        int want_n    = AUTOREPEAT ? 6 : 1;
        int want_last = AUTOREPEAT ? 61 : 9;
        clear_stim(90);
        for (int k = 2; k < 62; k++) raw_up[k] = 1'b1;
        build_model();
        for (int k = 0; k < n_steps; k++) begin
            apply_stimulus(k, o_en, o_up, o_ld, o_cin);
            n_checks++;
            if ({o_en, o_up, o_ld} !== {e_en[k], e_up[k], e_ld[k]}) begin
                n_fail++;
                $display("[TB] FAIL hold step %0d: en,up,load=%b%b%b expected %b%b%b", k, o_en, o_up, o_ld, e_en[k], e_up[k], e_ld[k]);
            end
            if (o_en === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
        end
        n_checks++;
        if (n_en != want_n || first_en != 9 || last_en != want_last) begin
            n_fail++;
            $display("[TB] FAIL hold_pulses: %0d pulses %0d..%0d, expected %0d pulses 9..%0d", n_en, first_en, last_en, want_n, want_last);
        end
    endtask

    task automatic test_random();
        logic o_en, o_up, o_ld;
        logic [3:0] o_cin;
        int k, len, mask;
        clear_stim(240);
        for (int j = 0; j < n_steps; j++) sw_v[j] = 4'($urandom);
        rst_v[$urandom_range(100, 140)] = 1'b0;
        k = 2;
        while (k + 40 < n_steps) begin
            k   += $urandom_range(10, 20);
            len  = $urandom_range(6, 15);
            mask = $urandom_range(1, 7);
            for (int j = k; j < k + len; j++) begin
                raw_up[j] = mask[0];
                raw_dn[j] = mask[1];
                raw_ld[j] = mask[2];
            end
            k += len;
        end
        build_model();
        for (int s = 0; s < n_steps; s++) begin
            apply_stimulus(s, o_en, o_up, o_ld, o_cin);
            n_checks++;
            if ({o_en, o_up, o_ld} !== {e_en[s], e_up[s], e_ld[s]}) begin
                n_fail++;
                $display("[TB] FAIL random step %0d: en,up,load=%b%b%b expected %b%b%b", s, o_en, o_up, o_ld, e_en[s], e_up[s], e_ld[s]);
            end
            n_checks++;
            if (o_cin !== e_cin[s]) begin
                n_fail++;
                $display("[TB] FAIL random_cin step %0d: count_in=%h expected %h", s, o_cin, e_cin[s]);
            end
        end
    endtask

    initial begin
        $display("[TB] cnt_ctrl bench start (autorepeat=%0d)", AUTOREPEAT);
        test_reset();
        test_clean_press();
        test_bounce();
        test_load_priority();
        test_reset_mid_debounce();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
